// File: rtl/wb_spi_master.sv
// wb_spi_master: Wishbone responder exposing a mode-0, MSB-first SPI controller with
// software chip select. Four byte registers: DATA, STATUS, CTRL, DIV.
module wb_spi_master #(
    parameter int unsigned              WB_ADDR_WIDTH = 20,
    parameter int unsigned              DATA_WIDTH    = 8,
    parameter logic [WB_ADDR_WIDTH-1:0] BASE_ADDR     = 'h0_E800,
    parameter logic [7:0]               DIV_RESET     = 8'd31
) (
    input  logic                     wb_clock_i,
    input  logic                     wb_reset_i,
    input  logic [WB_ADDR_WIDTH-1:0] wb_addr_i,
    input  logic [DATA_WIDTH-1:0]    wb_data_i,
    output logic [DATA_WIDTH-1:0]    wb_data_o,
    input  logic                     wb_we_i,
    input  logic                     wb_cycle_i,
    input  logic                     wb_strobe_i,
    output logic                     wb_stall_o,
    output logic                     wb_ack_o,
    output logic                     spi_sck_o,
    output logic                     spi_sd_o,
    input  logic                     spi_sd_i,
    output logic                     spi_cs_no,
    output logic                     irq_o
);

    typedef enum logic [1:0] {StIdle, StLow, StHigh, StDone} state_t;

    state_t                r_state;
    logic [7:0]            r_cnt;
    logic [7:0]            r_shift;
    logic [7:0]            r_rx;
    logic [7:0]            r_div;
    logic [2:0]            r_bit;
    logic                  r_sck;
    logic                  r_sd;
    logic                  r_rx_valid;
    logic                  r_cs;
    logic                  r_ie;
    logic                  r_ack;
    logic [DATA_WIDTH-1:0] r_data;

    logic       w_sel;
    logic       w_busy;
    logic       w_stall;
    logic       w_accept;
    logic       w_start;
    logic       w_rd_clear;
    logic [1:0] w_offset;
    logic [7:0] w_rdata;

    // BASE_ADDR is word aligned, so the upper address bits alone select the block.
    assign w_sel      = wb_cycle_i && wb_strobe_i &&
                        (wb_addr_i[WB_ADDR_WIDTH-1:2] == BASE_ADDR[WB_ADDR_WIDTH-1:2]);
    assign w_offset   = wb_addr_i[1:0];
    assign w_busy     = (r_state != StIdle);
    assign w_stall    = w_sel && wb_we_i && w_busy;
    assign w_accept   = w_sel && !w_stall;
    assign w_start    = w_accept && wb_we_i && (w_offset == 2'd0);
    assign w_rd_clear = w_accept && !wb_we_i && (w_offset == 2'd0);

    assign wb_stall_o = w_stall;
    assign wb_ack_o   = r_ack;
    assign wb_data_o  = r_data;
    assign spi_sck_o  = r_sck;
    assign spi_sd_o   = r_sd;
    assign spi_cs_no  = ~r_cs;
    assign irq_o      = r_rx_valid & r_ie;

    // Register read mux, sampled at the accept edge.
    always_comb begin
        w_rdata = 8'h00;
        case (w_offset)
            2'd0:    w_rdata = r_rx;
            2'd1:    w_rdata = {6'b0, r_rx_valid, w_busy};
            2'd2:    w_rdata = {6'b0, r_ie, r_cs};
            default: w_rdata = r_div;
        endcase
    end

    // Bus side: single-cycle ack, read data zero outside ack, CTRL and DIV writes.
    always_ff @(posedge wb_clock_i or posedge wb_reset_i) begin
        if (wb_reset_i) begin
            r_ack  <= 1'b0;
            r_data <= '0;
            r_cs   <= 1'b0;
            r_ie   <= 1'b0;
            r_div  <= DIV_RESET;
        end else begin
            r_ack  <= w_accept;
            r_data <= '0;
            if (w_accept && !wb_we_i) begin
                r_data <= DATA_WIDTH'(w_rdata);
            end
            if (w_accept && wb_we_i) begin
                if (w_offset == 2'd2) begin
                    r_cs <= wb_data_i[0];
                    r_ie <= wb_data_i[1];
                end else if (w_offset == 2'd3) begin
                    r_div <= wb_data_i[7:0];
                end
            end
        end
    end

    // Transfer engine. The shift register takes the received bit at each SCK rise while
    // r_sd keeps driving the current bit, so after eight rises it holds the whole RX byte.
    always_ff @(posedge wb_clock_i or posedge wb_reset_i) begin
        if (wb_reset_i) begin
            r_state    <= StIdle;
            r_cnt      <= 8'd0;
            r_bit      <= 3'd0;
            r_shift    <= 8'd0;
            r_sck      <= 1'b0;
            r_sd       <= 1'b0;
            r_rx       <= 8'd0;
            r_rx_valid <= 1'b0;
        end else begin
            if (w_rd_clear) begin
                r_rx_valid <= 1'b0;
            end
            case (r_state)
                StIdle: begin
                    if (w_start) begin
                        r_shift <= wb_data_i[7:0];
                        r_sd    <= wb_data_i[7];
                        r_bit   <= 3'd0;
                        r_cnt   <= 8'd0;
                        r_state <= StLow;
                    end
                end
                StLow: begin
                    if (r_cnt == r_div) begin
                        r_cnt   <= 8'd0;
                        r_sck   <= 1'b1;
                        r_shift <= {r_shift[6:0], spi_sd_i};
                        r_state <= StHigh;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                StHigh: begin
                    if (r_cnt == r_div) begin
                        r_cnt <= 8'd0;
                        r_sck <= 1'b0;
                        if (r_bit == 3'd7) begin
                            r_state <= StDone;
                        end else begin
                            r_sd    <= r_shift[7];
                            r_bit   <= r_bit + 3'd1;
                            r_state <= StLow;
                        end
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: begin
                    // Set wins over a same-cycle DATA read clear.
                    r_rx       <= r_shift;
                    r_rx_valid <= 1'b1;
                    r_state    <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_spi_master.sv
// Bench for wb_spi_master: directed checks plus randomized register traffic, with read
// data checked by a scoreboard against a transaction-level model of the register map.
`timescale 1ns/1ps
module tb_wb_spi_master;

    localparam int unsigned   AW   = 20;
    localparam logic [AW-1:0] BASE = 20'h0E800;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [7:0]    wdata = 8'h00;
    logic          we = 1'b0;
    logic          cyc = 1'b0;
    logic          stb = 1'b0;
    logic [7:0]    rdata;
    logic          stall, ack, sck, sdo, sdi, csn, irq;

    wb_spi_master #(
        .WB_ADDR_WIDTH (AW),
        .DATA_WIDTH    (8),
        .BASE_ADDR     (BASE),
        .DIV_RESET     (8'd31)
    ) dut (
        .wb_clock_i  (clk),
        .wb_reset_i  (rst),
        .wb_addr_i   (addr),
        .wb_data_i   (wdata),
        .wb_data_o   (rdata),
        .wb_we_i     (we),
        .wb_cycle_i  (cyc),
        .wb_strobe_i (stb),
        .wb_stall_o  (stall),
        .wb_ack_o    (ack),
        .spi_sck_o   (sck),
        .spi_sd_o    (sdo),
        .spi_sd_i    (sdi),
        .spi_cs_no   (csn),
        .irq_o       (irq)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int nc      = 0;  // negedge index, advanced by the monitor

    // Reference model: register contents plus one in-flight transfer whose result and
    // completion time are known at launch.
    logic [7:0] m_div = 8'd31;
    logic [7:0] m_rx = 8'h00;
    logic [7:0] m_pend = 8'h00;
    logic       m_cs = 1'b0;
    logic       m_ie = 1'b0;
    logic       m_rv = 1'b0;
    logic       m_pending = 1'b0;
    int         m_done = 0;  // negedge index whose following edge ends the transfer

    // SPI target: either loops MOSI back or shifts out a preset byte, MSB first.
    logic       loopback = 1'b0;
    logic [7:0] tgt = 8'h00;
    logic [2:0] rise_idx;
    assign sdi = loopback ? sdo : tgt[~rise_idx];

    always @(posedge sck or posedge rst) begin
        if (rst) rise_idx <= 3'd0;
        else     rise_idx <= rise_idx + 3'd1;
    end

    logic sd_log[$];
    int   hi_log[$];
    int   hi_run = 0;

    always @(posedge sck) sd_log.push_back(sdo);

    always @(negedge clk) begin
        if (sck) begin
            hi_run++;
        end else if (hi_run != 0) begin
            hi_log.push_back(hi_run);
            hi_run = 0;
        end
    end

    typedef struct {
        int         due;
        bit         chk;
        logic [7:0] data;
        string      name;
    } exp_t;
    exp_t  sb[$];
    string rn[4] = '{"DATA", "STATUS", "CTRL", "DIV"};

    task automatic check1(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic checki(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic eff_rv();
        return (m_pending && nc > m_done) ? 1'b1 : m_rv;
    endfunction

    task automatic retire(input int n, input bit incl);
        if (m_pending && (n > m_done || (incl && n == m_done))) begin
            m_rx      = m_pend;
            m_rv      = 1'b1;
            m_pending = 1'b0;
        end
    endtask

    task automatic model_reset();
        m_div = 8'd31; m_rx = 8'h00; m_cs = 1'b0; m_ie = 1'b0;
        m_rv = 1'b0; m_pending = 1'b0;
    endtask

    // Monitor: ack timing and read data from the scoreboard, plus per-cycle output checks.
    always @(negedge clk) begin
        nc++;
        if (!rst) begin
            if (sb.size() > 0 && sb[0].due == nc) begin
                check1({sb[0].name, " ack"}, ack, 1'b1);
                if (sb[0].chk) check8(sb[0].name, rdata, sb[0].data);
                void'(sb.pop_front());
            end else begin
                check1("stray ack", ack, 1'b0);
                check8("data outside ack", rdata, 8'h00);
            end
            check1("cs_n", csn, ~m_cs);
            check1("irq", irq, eff_rv() & m_ie);
            if (!m_pending) check1("sck idle", sck, 1'b0);
        end
    end

    // One Wishbone access; returns the number of cycles it was held by stall.
    task automatic bus(input logic [AW-1:0] a, input logic w, input logic [7:0] d,
                       input logic set_tgt, input logic lb, input logic [7:0] tb_byte,
                       output int stalls);
        logic       sel;
        logic [1:0] off;
        logic [7:0] exp;
        int         n;
        int         exp_stalls;
        string      pre;
        exp_t       e;
        @(negedge clk);
        #1;
        addr = a; we = w; wdata = d; cyc = 1'b1; stb = 1'b1;
        sel = (a >= BASE) && (a <= BASE + AW'(3));
        off = a[1:0];
        exp_stalls = (sel && w && m_pending && nc <= m_done) ? (m_done - nc + 1) : 0;
        stalls = 0;
        #1;
        while (stall === 1'b1 && stalls < 4000) begin
            @(negedge clk);
            #2;
            stalls++;
        end
        checki("stall cycles", stalls, exp_stalls);
        if (stalls >= 4000) begin
            cyc = 1'b0; stb = 1'b0; we = 1'b0;
            return;
        end
        n = nc;
        if (sel) begin
            retire(n, 1'b0);
            case (off)
                2'd0:    exp = m_rx;
                2'd1:    exp = {6'b0, m_rv, m_pending};
                2'd2:    exp = {6'b0, m_ie, m_cs};
                default: exp = m_div;
            endcase
            pre = w ? "wr " : "rd ";
            e.due = n + 1; e.chk = !w; e.data = exp; e.name = {pre, rn[off]};
            sb.push_back(e);
            if (!w && off == 2'd0) m_rv = 1'b0;
            retire(n, 1'b1);
            if (w) begin
                case (off)
                    2'd0: begin
                        if (set_tgt) begin loopback = lb; tgt = tb_byte; end
                        m_pend    = lb ? d : tb_byte;
                        m_pending = 1'b1;
                        m_done    = n + 16 * (int'(m_div) + 1) + 1;
                    end
                    2'd2:    begin m_cs = d[0]; m_ie = d[1]; end
                    2'd3:    m_div = d;
                    default: ;
                endcase
            end
        end
        @(posedge clk);
        #1;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic wr(input logic [1:0] off, input logic [7:0] d);
        int s;
        bus(BASE + AW'(off), 1'b1, d, 1'b0, 1'b0, 8'h00, s);
    endtask

    task automatic rd(input logic [1:0] off);
        int s;
        bus(BASE + AW'(off), 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, s);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int            s;
        logic [7:0]    b;
        logic [AW-1:0] a;
        #2 rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check1("reset sck", sck, 1'b0);
        check1("reset cs_n", csn, 1'b1);
        check1("reset ack", ack, 1'b0);
        check1("reset irq", irq, 1'b0);
        check1("reset sdo", sdo, 1'b0);
        check1("reset stall", stall, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) rd(2'(i));

        // Loopback, DIV=0.
        wr(2'd3, 8'h00);
        wr(2'd2, 8'h01);
        sd_log.delete();
        hi_log.delete();
        bus(BASE, 1'b1, 8'hA5, 1'b1, 1'b1, 8'h00, s);
        bus(BASE + AW'(1), 1'b1, 8'hFF, 1'b0, 1'b0, 8'h00, s);
        checki("busy length div0", s, 17);
        b = 8'hA5;
        checki("sck pulses", sd_log.size(), 8);
        if (sd_log.size() == 8)
            for (int i = 0; i < 8; i++) check1("sdo at sck rise", sd_log[i], b[7 - i]);
        checki("sck high runs", hi_log.size(), 8);
        foreach (hi_log[i]) checki("sck high width", hi_log[i], 1);
        rd(2'd1);
        rd(2'd0);
        rd(2'd1);

        // DIV=3, back-to-back DATA writes; target answers 5A.
        wr(2'd3, 8'h03);
        bus(BASE, 1'b1, 8'h3C, 1'b1, 1'b0, 8'h5A, s);
        bus(BASE, 1'b1, 8'hC3, 1'b1, 1'b0, 8'h96, s);
        checki("second write stall", s, 65);
        rd(2'd0);
        rd(2'd1);

        // Interrupt rises with RX_VALID, drops on DATA read.
        wr(2'd2, 8'h03);
        rd(2'd0);
        bus(BASE, 1'b1, 8'h81, 1'b1, 1'b0, 8'h42, s);
        while (nc < m_done - 1) @(negedge clk);
        #1 check1("irq before done", irq, 1'b0);
        while (nc < m_done + 1) @(negedge clk);
        #1 check1("irq after done", irq, 1'b1);
        rd(2'd0);
        @(negedge clk);
        #1 check1("irq after read", irq, 1'b0);

        // Reset during bit 4 of a DIV=7 transfer.
        wr(2'd3, 8'h07);
        bus(BASE, 1'b1, 8'($urandom), 1'b1, 1'b0, 8'($urandom), s);
        for (int k = 0; k < 2000 && !(rise_idx == 3'd5 && sck); k++) @(negedge clk);
        check1("reached bit 4", (rise_idx == 3'd5) && sck, 1'b1);
        #2 rst = 1'b1;
        #1;
        check1("mid reset sck", sck, 1'b0);
        check1("mid reset cs_n", csn, 1'b1);
        check1("mid reset irq", irq, 1'b0);
        check1("mid reset ack", ack, 1'b0);
        addr = BASE; we = 1'b1; cyc = 1'b1; stb = 1'b1;
        #1 check1("mid reset busy stall", stall, 1'b0);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        model_reset();
        @(negedge clk);
        #1 rst = 1'b0;
        rd(2'd3);
        rd(2'd1);
        rd(2'd2);

        // Out-of-range accesses: no ack, no side effects.
        bus(BASE + AW'(4), 1'b1, 8'h55, 1'b0, 1'b0, 8'h00, s);
        bus(BASE - AW'(1), 1'b1, 8'hAA, 1'b0, 1'b0, 8'h00, s);
        bus(BASE + AW'(4), 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, s);
        bus(BASE - AW'(1), 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, s);
        rd(2'd2);
        rd(2'd3);
        wr(2'd3, 8'h01);

        // Randomized traffic.
        for (int k = 0; k < 60; k++) begin
            int unsigned op;
            op = $urandom_range(0, 5);
            case (op)
                0: wr(2'd3, 8'($urandom_range(0, 3)));
                1: wr(2'd2, 8'($urandom));
                2: bus(BASE, 1'b1, 8'($urandom), 1'b1, 1'($urandom), 8'($urandom), s);
                3: rd(2'($urandom));
                4: wr(2'd1, 8'($urandom));
                default: begin
                    if ($urandom_range(0, 1) == 1) a = BASE + AW'(4 + $urandom_range(0, 15));
                    else                           a = BASE - AW'(1 + $urandom_range(0, 15));
                    bus(a, 1'($urandom), 8'($urandom), 1'b0, 1'b0, 8'h00, s);
                end
            endcase
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        bus(BASE + AW'(1), 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, s);
        rd(2'd0);
        rd(2'd1);
        repeat (3) @(negedge clk);
        checki("scoreboard drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
